// File: rtl/distance_nd_if.sv
// ---------------------------------------------------------------------------
// distance_nd_if
// Bundles the query, vertex-gather and result signals of distance_nd.
//   slave  modport : the distance unit itself
//   master modport : whoever drives vertices and consumes results
//
// Handshake rules (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. Vertex side: each vertex_valid_in[i] is an independent component
//   valid sharing the single vertex_ready_out. Result side: once
//   dist_valid_out is high, dist_out holds stable until dist_ready_in is seen.
//
// Signals:
//   clear_in          sync flush of gather flags and pipeline (query kept)
//   query_load_in     capture query_pos_in into the query register
//   query_pos_in      query coordinates, DIM x WIDTH
//   vertex_valid_in   per-dimension component valid
//   vertex_pos_in     vertex coordinates, DIM x WIDTH
//   vertex_ready_out  components accepted this cycle
//   mode_in           0 = squared Euclidean, 1 = Manhattan
//   dist_out          distance result
//   dist_valid_out    result valid
//   dist_ready_in     downstream accepts result
//   overflow_out      result saturated
//   result_count_out  number of results handed off (wraps)
// ---------------------------------------------------------------------------
interface distance_nd_if #(
    parameter int DIM       = 4,
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 32
);
    logic                            clear_in;
    logic                            query_load_in;
    logic [DIM-1:0][WIDTH-1:0]       query_pos_in;
    logic [DIM-1:0]                  vertex_valid_in;
    logic [DIM-1:0][WIDTH-1:0]       vertex_pos_in;
    logic                            vertex_ready_out;
    logic                            mode_in;
    logic [OUT_WIDTH-1:0]            dist_out;
    logic                            dist_valid_out;
    logic                            dist_ready_in;
    logic                            overflow_out;
    logic [15:0]                     result_count_out;

    modport slave (
        input  clear_in, query_load_in, query_pos_in,
        input  vertex_valid_in, vertex_pos_in, mode_in, dist_ready_in,
        output vertex_ready_out, dist_out, dist_valid_out,
        output overflow_out, result_count_out
    );

    modport master (
        output clear_in, query_load_in, query_pos_in,
        output vertex_valid_in, vertex_pos_in, mode_in, dist_ready_in,
        input  vertex_ready_out, dist_out, dist_valid_out,
        input  overflow_out, result_count_out
    );
endinterface

// File: rtl/distance_nd.sv
// ---------------------------------------------------------------------------
// distance_nd
// N-dimensional distance unit: gathers vertex components (possibly on
// different cycles), then computes squared-Euclidean or Manhattan distance
// to a held query point in a 3-stage pipeline with valid/ready backpressure.
//
// Ports:
//   clk_in    system clock
//   rst_n_in  asynchronous active-low reset
//   bus       distance_nd_if.slave (query, vertex gather, result channel)
//
// Optional feature (macro DISTANCE_SAT_EN):
//   defined   : sums above 2^OUT_WIDTH-1 give all-ones and overflow_out = 1
//   undefined : dist_out is the low OUT_WIDTH bits of the sum, overflow_out = 0
// ---------------------------------------------------------------------------
module distance_nd #(
    parameter int DIM       = 4,
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    distance_nd_if.slave  bus
);
`ifdef DISTANCE_SAT_EN
    localparam int LOG_D = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int SUM_W = 2 * WIDTH + LOG_D;
    localparam int EXT_W = (SUM_W > OUT_WIDTH) ? SUM_W : OUT_WIDTH;
`endif

    // query and gather registers
    logic [DIM-1:0][WIDTH-1:0]   query_q, query_d;
    logic [DIM-1:0]              flag_q, flag_d;
    logic [DIM-1:0][WIDTH-1:0]   val_q, val_d;
    // stage 1: signed differences
    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_mode_q, s1_mode_d;
    logic [DIM-1:0][WIDTH:0]     s1_diff_q, s1_diff_d;
    // stage 2: per-dimension terms
    logic                        s2_valid_q, s2_valid_d;
    logic [DIM-1:0][2*WIDTH-1:0] s2_term_q, s2_term_d;
    // stage 3: output register
    logic [OUT_WIDTH-1:0]        dist_q, dist_d;
    logic                        dist_valid_q, dist_valid_d;
    logic [15:0]                 count_q, count_d;
`ifdef DISTANCE_SAT_EN
    logic                        ovf_q, ovf_d;
    logic [EXT_W-1:0]            sum_ext;
`else
    logic [OUT_WIDTH-1:0]        sum_red;
`endif

    logic                        all_flags, out_adv, s2_can, s1_can, launch;
    logic                        vertex_ready;
    logic [DIM-1:0]              capture;
    logic [DIM-1:0][WIDTH-1:0]   mag;

    always_comb begin
        all_flags    = &flag_q;
        // each stage moves when its successor is empty or moving
        out_adv      = !dist_valid_q || bus.dist_ready_in;
        s2_can       = !s2_valid_q || out_adv;
        s1_can       = !s1_valid_q || s2_can;
        launch       = all_flags && s1_can && !bus.clear_in;
        vertex_ready = !(all_flags && !launch);
        capture      = bus.vertex_valid_in & {DIM{vertex_ready && !bus.clear_in}};

        query_d = query_q;
        if (bus.query_load_in) begin
            query_d = bus.query_pos_in;
        end

        // launch empties the gather; a component arriving on the same edge
        // starts the next vertex
        flag_d = launch ? '0 : flag_q;
        val_d  = val_q;
        for (int i = 0; i < DIM; i++) begin
            if (capture[i]) begin
                flag_d[i] = 1'b1;
                val_d[i]  = bus.vertex_pos_in[i];
            end
        end
        if (bus.clear_in) begin
            flag_d = '0;
        end

        // stage 1: launch reads the registered query, so a load in the same
        // cycle only affects later vertices
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_diff_d  = s1_diff_q;
        if (s1_can) begin
            s1_valid_d = launch;
            if (launch) begin
                s1_mode_d = bus.mode_in;
                for (int i = 0; i < DIM; i++) begin
                    s1_diff_d[i] = {1'b0, val_q[i]} - {1'b0, query_q[i]};
                end
            end
        end
        if (bus.clear_in) begin
            s1_valid_d = 1'b0;
        end

        // stage 2: |d| always fits WIDTH bits since |d| <= 2^WIDTH-1
        for (int i = 0; i < DIM; i++) begin
            mag[i] = s1_diff_q[i][WIDTH] ? WIDTH'(-s1_diff_q[i]) : s1_diff_q[i][WIDTH-1:0];
        end
        s2_valid_d = s2_valid_q;
        s2_term_d  = s2_term_q;
        if (s2_can) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                for (int i = 0; i < DIM; i++) begin
                    s2_term_d[i] = s1_mode_q ? {{WIDTH{1'b0}}, mag[i]}
                                             : {{WIDTH{1'b0}}, mag[i]} * {{WIDTH{1'b0}}, mag[i]};
                end
            end
        end
        if (bus.clear_in) begin
            s2_valid_d = 1'b0;
        end

        // stage 3: reduce the full-precision sum to OUT_WIDTH
        dist_valid_d = dist_valid_q;
        dist_d       = dist_q;
`ifdef DISTANCE_SAT_EN
        ovf_d   = ovf_q;
        sum_ext = '0;
        for (int i = 0; i < DIM; i++) begin
            sum_ext = sum_ext + EXT_W'(s2_term_q[i]);
        end
`else
        // modular accumulation at OUT_WIDTH equals the low bits of the full sum
        sum_red = '0;
        for (int i = 0; i < DIM; i++) begin
            sum_red = sum_red + OUT_WIDTH'(s2_term_q[i]);
        end
`endif
        if (out_adv) begin
            dist_valid_d = s2_valid_q;
            if (s2_valid_q) begin
`ifdef DISTANCE_SAT_EN
                if ((sum_ext >> OUT_WIDTH) != '0) begin
                    dist_d = '1;
                    ovf_d  = 1'b1;
                end else begin
                    dist_d = sum_ext[OUT_WIDTH-1:0];
                    ovf_d  = 1'b0;
                end
`else
                dist_d = sum_red;
`endif
            end
        end
        if (bus.clear_in) begin
            dist_valid_d = 1'b0;
        end

        // a flush cancels the handoff of the result it drops
        count_d = count_q;
        if (dist_valid_q && bus.dist_ready_in && !bus.clear_in) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            query_q      <= '0;
            flag_q       <= '0;
            val_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_diff_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_term_q    <= '0;
            dist_q       <= '0;
            dist_valid_q <= 1'b0;
            count_q      <= '0;
`ifdef DISTANCE_SAT_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            query_q      <= query_d;
            flag_q       <= flag_d;
            val_q        <= val_d;
            s1_valid_q   <= s1_valid_d;
            s1_mode_q    <= s1_mode_d;
            s1_diff_q    <= s1_diff_d;
            s2_valid_q   <= s2_valid_d;
            s2_term_q    <= s2_term_d;
            dist_q       <= dist_d;
            dist_valid_q <= dist_valid_d;
            count_q      <= count_d;
`ifdef DISTANCE_SAT_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign bus.vertex_ready_out = vertex_ready;
    assign bus.dist_out         = dist_q;
    assign bus.dist_valid_out   = dist_valid_q;
    assign bus.result_count_out = count_q;
`ifdef DISTANCE_SAT_EN
    assign bus.overflow_out     = ovf_q;
`else
    assign bus.overflow_out     = 1'b0;
`endif
endmodule

// File: doc/distance_nd.md
Name: distance_nd

Overview:
Parametrised N-dimensional distance unit for the nearest-neighbour search datapath. It is the successor to the 2-D squared-distance calculator.
- Holds a query point; gathers vertex components, which may arrive per dimension on different cycles.
- Computes squared-Euclidean or Manhattan distance in a 3-stage pipeline.
- Result leaves on a valid/ready output with backpressure.

Parameters:
DIM, 4, number of dimensions (>=1)
WIDTH, 32, unsigned coordinate width per dimension
OUT_WIDTH, 32, result width; internal full-precision sum is 2*WIDTH+$clog2(DIM) bits (min 1)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous, active-low reset
clear_in  input  1  synchronous flush of gather flags and pipeline; query register kept
query_load_in  input  1  capture query_pos_in (all dims)
query_pos_in  input  [WIDTH-1:0] x DIM  query coordinates
vertex_valid_in  input  [DIM-1:0]  per-dimension component valid
vertex_pos_in  input  [WIDTH-1:0] x DIM  vertex coordinates
vertex_ready_out  output  1  components accepted this cycle
mode_in  input  1  0 = squared Euclidean, 1 = Manhattan; sampled at launch
dist_out  output  OUT_WIDTH  distance result
dist_valid_out  output  1  result valid
dist_ready_in  input  1  downstream accepts result
overflow_out  output  1  result exceeded OUT_WIDTH (see Optional Feature)
result_count_out  output  16  count of results handed off

Behaviour:
- Reset (rst_n_in low, async): gather flags, stage valids, dist_valid_out, overflow_out and result_count_out all = 0; dist_out = 0; query register = 0.
- Query register: loads all DIM coordinates on the edge where query_load_in=1.
  - A launch in the same cycle uses the OLD query.
  - Items already in the pipeline are unaffected by a query load.
- Gather: per-dimension flag[i] and value register.
  - Component i is captured when vertex_valid_in[i] && vertex_ready_out.
  - A repeat on an already-flagged dimension overwrites it; latest value wins.
- Launch: occurs when all flags are set (registered) and stage 1 can advance.
  - On launch, flags clear, and value/query/mode move into stage 1.
  - Components valid on the launch cycle are captured for the next vertex.
- vertex_ready_out = !(all flags set && !launch). Components presented while it is low are ignored.
- Stage 1: d[i] = vertex[i] - query[i], signed WIDTH+1 bits.
- Stage 2: mode 0 gives d[i]^2 (2*WIDTH bits unsigned); mode 1 gives |d[i]| (WIDTH bits).
- Stage 3: sum over DIM at full precision, reduced to OUT_WIDTH, then registered to dist_out and dist_valid_out.
- Latency: if the last component is captured at edge E, dist_valid_out is high after edge E+3, given no stall.
- Throughput: one vertex per cycle when every dimension is valid each cycle.
- Backpressure: each stage advances iff its successor is empty or advancing.
  - Output register advances iff !dist_valid_out || dist_ready_in.
  - dist_out and dist_valid_out hold stable while valid && !ready.
- Handoff: result_count_out increments on each dist_valid_out && dist_ready_in, and wraps at 16'hFFFF -> 0.
- clear_in: stage valids and flags go to 0, and no capture happens that cycle. Query, counter and dist_out value are kept; dist_valid_out drops.
- Reset mid-operation discards everything in flight.

Optional Feature:
DISTANCE_SAT_EN
- Defined: if the full-precision sum exceeds 2^OUT_WIDTH-1, dist_out = all-ones and overflow_out = 1 for that result. Otherwise overflow_out = 0.
- Undefined: dist_out = low OUT_WIDTH bits of the sum (wraps), and overflow_out is tied 0.

Test Plan:
1. DIM=2, query=(18,23090); comp0=2938 at cycle t, comp1=223 at t+1, mode 0 -> dist_out=531426089, valid exactly 3 cycles after the comp1 capture edge; ready high throughout.
2. Same vectors, mode 1 -> dist_out=25787; then query_load_in in the launch cycle with a new query (0,0) -> that result still equals 25787.
3. DIM=2, query=(0,0), 8 back-to-back vertices (k,k), k=1..8, all dims valid every cycle, dist_ready_in low for cycles 3-6 -> outputs 2k^2 (2,8,...,128) in order, none lost or duplicated, vertex_ready_out low while full; result_count_out=8 at end.
4. query=(0,0), vertex=(70000,0), mode 0 -> with DISTANCE_SAT_EN: dist_out=32'hFFFFFFFF, overflow_out=1; without: dist_out=605032704, overflow_out=0.
5. comp0 given twice (100 then 50) before comp1=0 with query=(0,0) -> 2500 (latest wins); clear_in after a single component, then a fresh full vertex -> only the fresh result appears.
6. rst_n_in pulsed low asynchronously (mid-clock) with 3 results in flight and dist_valid_out high -> all outputs 0 immediately, no results afterward, query reads back 0.
